// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage write enables and bubble flushes from memory
// handshakes, load-use hazards, jumps, taken branches and halt.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DWAIT_MAX = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       idrsel1,
  input  logic [4:0]       idrsel2,
  input  logic             excuDRE,
  input  logic             exWEN,
  input  logic [4:0]       exwsel,
  input  logic             memcuDRE,
  input  logic             memcuDWE,
  input  logic             mem_brnch_taken,
  input  logic             id_jump,
  input  logic             mem_halt,
  output logic             pcWEN,
  output logic             ifW,
  output logic             idW,
  output logic             exW,
  output logic             memW,
  output logic             ifFLUSH,
  output logic             idFLUSH,
  output logic             exFLUSH,
  output logic             halt,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(DWAIT_MAX + 1);

  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

  state_t            state, state_nx;
  logic              dmem_pend;
  logic              load_use;
  logic              branch_fire;
  logic              waiting;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;

  assign dmem_pend = (memcuDRE | memcuDWE) & ~dhit;
  assign load_use  = excuDRE & exWEN & (exwsel != 5'd0) &
                     ((exwsel == idrsel1) | (exwsel == idrsel2));
  // A pending access in the first RUN cycle already counts toward the watchdog
  assign waiting   = (state != HALTED) & dmem_pend;
  assign wait_inc  = (wait_cnt == WAIT_W'(DWAIT_MAX)) ? wait_cnt : wait_cnt + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RUN;
      halt         <= 1'b0;
      dmem_timeout <= 1'b0;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state <= state_nx;
      halt  <= (state_nx == HALTED);
      if (waiting) begin
        wait_cnt <= wait_inc;
        if (wait_inc == WAIT_W'(DWAIT_MAX)) dmem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if ((state != HALTED) && !pcWEN && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_fire && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Next state plus priority-ordered Mealy control outputs
  always_comb begin
    state_nx    = state;
    pcWEN       = 1'b0;
    ifW         = 1'b0;
    idW         = 1'b0;
    exW         = 1'b0;
    memW        = 1'b0;
    ifFLUSH     = 1'b0;
    idFLUSH     = 1'b0;
    exFLUSH     = 1'b0;
    branch_fire = 1'b0;

    case (state)
      HALTED: state_nx = HALTED;
      default: begin
        if (mem_halt && !dmem_pend) state_nx = HALTED;
        else if (dmem_pend)         state_nx = DWAIT;
        else                        state_nx = RUN;
      end
    endcase

    if (state == HALTED || dmem_pend) begin
      pcWEN = 1'b0;
    end else if (mem_brnch_taken) begin
      pcWEN       = 1'b1;
      {ifW, idW, exW, memW}       = 4'b1111;
      {ifFLUSH, idFLUSH, exFLUSH} = 3'b111;
      branch_fire = 1'b1;
    end else if (load_use) begin
      {idW, exW, memW} = 3'b111;
      idFLUSH          = 1'b1;
    end else if (id_jump) begin
      pcWEN   = ihit;
      {ifW, idW, exW, memW} = 4'b1111;
      ifFLUSH = 1'b1;
    end else if (!ihit) begin
      {ifW, idW, exW, memW} = 4'b1111;
      ifFLUSH = 1'b1;
    end else begin
      pcWEN = 1'b1;
      {ifW, idW, exW, memW} = 4'b1111;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a behavioural
// model that tracks only halted/wait-length/counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DWAIT_MAX = 2;
  localparam int          SAT       = (1 << CNT_W) - 1;

  logic             CLK, nRST;
  logic             ihit, dhit, excuDRE, exWEN, memcuDRE, memcuDWE;
  logic             mem_brnch_taken, id_jump, mem_halt;
  logic [4:0]       idrsel1, idrsel2, exwsel;
  logic             pcWEN, ifW, idW, exW, memW, ifFLUSH, idFLUSH, exFLUSH;
  logic             halt, dmem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]       dut_vec;

  int passed = 0;
  int total  = 0;

  bit m_halted, m_to;
  int m_wait, m_stall, m_flush;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DWAIT_MAX(DWAIT_MAX)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .idrsel1(idrsel1), .idrsel2(idrsel2), .excuDRE(excuDRE), .exWEN(exWEN),
    .exwsel(exwsel), .memcuDRE(memcuDRE), .memcuDWE(memcuDWE),
    .mem_brnch_taken(mem_brnch_taken), .id_jump(id_jump), .mem_halt(mem_halt),
    .pcWEN(pcWEN), .ifW(ifW), .idW(idW), .exW(exW), .memW(memW),
    .ifFLUSH(ifFLUSH), .idFLUSH(idFLUSH), .exFLUSH(exFLUSH),
    .halt(halt), .dmem_timeout(dmem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign dut_vec = {pcWEN, ifW, idW, exW, memW, ifFLUSH, idFLUSH, exFLUSH};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic bit m_pend();
    return (memcuDRE || memcuDWE) && !dhit;
  endfunction

  // Expected {pcWEN,ifW,idW,exW,memW,ifFLUSH,idFLUSH,exFLUSH} from the priority rules
  function automatic logic [7:0] m_outs();
    bit lu;
    lu = excuDRE && exWEN && exwsel != 5'd0 && (exwsel == idrsel1 || exwsel == idrsel2);
    if (m_halted || m_pend()) return 8'b0000_0000;
    if (mem_brnch_taken)      return 8'b1111_1111;
    if (lu)                   return 8'b0011_1010;
    if (id_jump)              return {ihit, 7'b1111_100};
    if (!ihit)                return 8'b0111_1100;
    return 8'b1111_1000;
  endfunction

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; excuDRE = 1'b0; exWEN = 1'b0; memcuDRE = 1'b0;
    memcuDWE = 1'b0; mem_brnch_taken = 1'b0; id_jump = 1'b0; mem_halt = 1'b0;
    idrsel1 = 5'd0; idrsel2 = 5'd0; exwsel = 5'd0;
  endtask

  task automatic randomize_inputs();
    ihit            = ($urandom_range(0, 9) < 8);
    dhit            = ($urandom_range(0, 1) == 1);
    memcuDRE        = ($urandom_range(0, 9) < 2);
    memcuDWE        = ($urandom_range(0, 9) < 1);
    mem_brnch_taken = ($urandom_range(0, 9) < 1);
    id_jump         = ($urandom_range(0, 9) < 1);
    mem_halt        = ($urandom_range(0, 99) < 2);
    excuDRE         = ($urandom_range(0, 9) < 3);
    exWEN           = ($urandom_range(0, 9) < 7);
    idrsel1         = 5'($urandom_range(0, 3));
    idrsel2         = 5'($urandom_range(0, 3));
    exwsel          = 5'($urandom_range(0, 3));
  endtask

  task automatic sample();
    @(negedge CLK);
    chk("ctrl", 32'(dut_vec), 32'(m_outs()));
    chk("halt", 32'(halt), 32'(m_halted));
    chk("dmem_timeout", 32'(dmem_timeout), 32'(m_to));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle
  task automatic step();
    logic [7:0] e;
    bit pend;
    e    = m_outs();
    pend = m_pend();
    @(posedge CLK);
    if (!m_halted) begin
      if (!e[7] && m_stall < SAT) m_stall++;
      if (mem_brnch_taken && !pend && m_flush < SAT) m_flush++;
      if (pend) begin
        m_wait++;
        if (m_wait >= DWAIT_MAX) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
      if (mem_halt && !pend) m_halted = 1'b1;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    step();
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b0;
    #2;
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_timeout", 32'(dmem_timeout), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    chk("rst_ctrl", 32'(dut_vec), 32'h0F8);
    m_halted = 1'b0; m_to = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
    #1 nRST = 1'b1;
  endtask

  initial begin
    idle();
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    do_reset();

    // Reset in the middle of a data-memory wait
    memcuDRE = 1'b1;
    cyc();
    cyc();
    do_reset();
    sample();
    chk("rst_pcWEN", 32'(pcWEN), 32'd1);
    step();

    // Load-use: one stall cycle, then the bubble clears it; r0 never hazards
    excuDRE = 1'b1; exWEN = 1'b1; exwsel = 5'd5; idrsel2 = 5'd5;
    sample();
    chk("lu_ctrl", 32'(dut_vec), 32'h03A);
    step();
    excuDRE = 1'b0;
    sample();
    chk("lu_after", 32'(dut_vec), 32'h0F8);
    chk("lu_stall", 32'(stall_cnt), 32'd1);
    step();
    excuDRE = 1'b1; exwsel = 5'd0; idrsel2 = 5'd0;
    sample();
    chk("lu_r0_ctrl", 32'(dut_vec), 32'h0F8);
    step();
    sample();
    chk("lu_r0_stall", 32'(stall_cnt), 32'd1);
    step();

    // Data-memory wait of 3 cycles, watchdog at 2
    do_reset();
    memcuDRE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("dw_ctrl", 32'(dut_vec), 32'h000);
      chk("dw_timeout", 32'(dmem_timeout), (i == 2) ? 32'd1 : 32'd0);
      step();
    end
    dhit = 1'b1;
    sample();
    chk("dw_hit_ctrl", 32'(dut_vec), 32'h0F8);
    step();
    idle();
    sample();
    chk("dw_stall", 32'(stall_cnt), 32'd3);
    chk("dw_timeout_sticky", 32'(dmem_timeout), 32'd1);
    step();

    // Branch together with a load-use hazard
    do_reset();
    mem_brnch_taken = 1'b1; excuDRE = 1'b1; exWEN = 1'b1; exwsel = 5'd7; idrsel1 = 5'd7;
    sample();
    chk("br_ctrl", 32'(dut_vec), 32'h0FF);
    step();
    idle();
    sample();
    chk("br_flush", 32'(flush_cnt), 32'd1);
    chk("br_stall", 32'(stall_cnt), 32'd0);
    step();

    // Jump during an instruction miss, then the fetch completes
    id_jump = 1'b1; ihit = 1'b0;
    sample();
    chk("jmp_miss_ctrl", 32'(dut_vec), 32'h07C);
    step();
    ihit = 1'b1;
    sample();
    chk("jmp_hit_ctrl", 32'(dut_vec), 32'h0FC);
    step();

    // Halt behind a pending store
    do_reset();
    mem_halt = 1'b1; memcuDWE = 1'b1;
    cyc();
    cyc();
    dhit = 1'b1;
    sample();
    chk("hlt_hit_ctrl", 32'(dut_vec), 32'h0F8);
    chk("hlt_not_yet", 32'(halt), 32'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      randomize_inputs();
      sample();
      chk("hlt_ctrl", 32'(dut_vec), 32'h000);
      chk("hlt_halt", 32'(halt), 32'd1);
      chk("hlt_stall", 32'(stall_cnt), 32'd2);
      step();
    end
    do_reset();

    // Counter saturation
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    idle();
    sample();
    chk("stall_sat", 32'(stall_cnt), 32'(SAT));
    step();
    mem_brnch_taken = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    sample();
    chk("flush_sat", 32'(flush_cnt), 32'(SAT));
    step();

    // Random segments
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        randomize_inputs();
        cyc();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-register write enables and flush (bubble-insert) controls from memory handshakes, load-use hazards, jumps, taken branches and halt.
- Tracks a data-memory wait FSM with a watchdog, a sticky halt state, and saturating stall/flush statistics counters.

Parameters:
- CNT_W, 16, width of the stall and flush statistic counters.
- DWAIT_MAX, 255, consecutive data-memory wait cycles before dmem_timeout is raised.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- idrsel1  in  5  rs of instruction in ID.
- idrsel2  in  5  rt of instruction in ID.
- excuDRE  in  1  EX-stage instruction is a load.
- exWEN  in  1  EX-stage instruction writes the register file.
- exwsel  in  5  EX-stage destination register.
- memcuDRE  in  1  MEM-stage load.
- memcuDWE  in  1  MEM-stage store.
- mem_brnch_taken  in  1  branch resolved taken in MEM.
- id_jump  in  1  J/JAL/JR decoded in ID.
- mem_halt  in  1  HALT instruction in MEM.
- pcWEN  out  1  PC update enable.
- ifW, idW, exW, memW  out  1 each  enables for IF/ID, ID/EX, EX/MEM, MEM/WB.
- ifFLUSH, idFLUSH, exFLUSH  out  1 each  load a bubble into IF/ID, ID/EX, EX/MEM at the next edge.
- halt  out  1  sticky, registered.
- dmem_timeout  out  1  sticky, registered.
- stall_cnt  out  CNT_W  saturating count of cycles with pcWEN=0 in RUN/DWAIT.
- flush_cnt  out  CNT_W  saturating count of branch-flush events.

Behaviour:
- Interface is fixed: one clock; asynchronous active-low reset. Clock port is CLK, reset port is nRST.
- Reset (nRST=0, asynchronous):
  - state=RUN; halt=0; dmem_timeout=0; wait counter=0; stall_cnt=0; flush_cnt=0.
  - Combinational outputs evaluate in RUN.
- FSM states RUN, DWAIT, HALTED.
  - dmem_pend = (memcuDRE|memcuDWE) & ~dhit.
  - RUN -> DWAIT when dmem_pend.
  - DWAIT -> RUN on dhit.
  - RUN or DWAIT -> HALTED on the edge where mem_halt=1 and ~dmem_pend.
  - HALTED is exited only by reset.
- Control outputs are combinational (Mealy). Priority, highest first:
  1. HALTED: all enables 0, all flushes 0, pcWEN=0; halt=1 from the first HALTED cycle.
  2. dmem_pend, in RUN or DWAIT: freeze; pcWEN, ifW, idW, exW, memW all 0; flushes 0.
  3. mem_brnch_taken: pcWEN=1 (target loaded regardless of ihit); all W=1; ifFLUSH=idFLUSH=exFLUSH=1; flush_cnt+1.
  4. Load-use: excuDRE & exWEN & exwsel!=0 & (exwsel==idrsel1 | exwsel==idrsel2).
     - pcWEN=0, ifW=0 (hold IF/ID), idFLUSH=1, exW=memW=1.
     - Lasts exactly one cycle, because the bubble clears the EX-stage condition.
  5. id_jump: pcWEN=ihit; all W=1; ifFLUSH=1.
  6. ~ihit: pcWEN=0; ifW=1 with ifFLUSH=1 (bubble); idW=exW=memW=1.
  7. Otherwise: pcWEN=1, all W=1, flushes 0.
- A flush overrides its register's W: the register loads the bubble even if W=0.
- Wait counter:
  - Increments each DWAIT cycle and clears on leaving DWAIT.
  - When it reaches DWAIT_MAX, dmem_timeout is set (sticky). The freeze continues.
- stall_cnt increments on any RUN/DWAIT cycle with pcWEN=0 and holds at 2^CNT_W-1. flush_cnt saturates the same way.
- Simultaneous events:
  - Branch plus load-use: branch wins, so the hazard instruction is squashed.
  - Branch plus dmem_pend: freeze wins, and the branch is applied on the dhit cycle.
  - mem_halt plus mem_brnch_taken: HALTED wins on the next edge.
- Reset mid-DWAIT or mid-HALTED returns immediately to RUN, with all counters cleared.

Test Plan:
- Reset: nRST=0 mid-DWAIT -> state RUN, halt=0, stall_cnt=0, and pcWEN=1 once ihit=1.
- Load-use: excuDRE=1, exWEN=1, exwsel=5, idrsel2=5, ihit=1 -> exactly one cycle of pcWEN=0, ifW=0, idFLUSH=1; stall_cnt=1. Repeating with exwsel=0 -> no stall.
- Dmem wait: memcuDRE=1, dhit=0 for 3 cycles, then dhit=1 -> all W=0 for 3 cycles, all W=1 on the dhit cycle, stall_cnt=3. Same test with DWAIT_MAX=2 -> dmem_timeout=1 after cycle 2.
- Branch: mem_brnch_taken=1 together with the load-use condition -> ifFLUSH=idFLUSH=exFLUSH=1, pcWEN=1, flush_cnt=1, and no stall.
- Jump plus imiss: id_jump=1, ihit=0 -> pcWEN=0, ifFLUSH=1; then ihit=1 -> pcWEN=1.
- Halt: mem_halt=1, memcuDWE=1, dhit=0 for 2 cycles, then dhit=1 -> HALTED after the dhit edge, halt=1, all enables 0 thereafter until nRST=0.
